ila_readout_engine: RTL and testbench

//  Downstream readout stage of the internal logic analyzer. After a capture completes, it walks the capture buffer in

---
 rtl/ila_pkg.sv | 20 ++
 rtl/ila_word_serializer.sv | 46 ++++
 rtl/ila_readout_engine.sv | 133 +++++++++++++
 tb/tb_ila_readout_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ila_pkg.sv
// Shared types and defaults for the internal logic analyzer blocks.
package ila_pkg;

    localparam int ILA_READOUT_WORD_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        FETCH,
        WAIT,
        SEND
    } ila_readout_state_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic last;
    } ila_status_t;

endpackage

// File: rtl/ila_word_serializer.sv
// Holds one captured sample and hands it out one stream word at a time, least-significant word first.
module ila_word_serializer #(
    parameter int SAMPLE_WIDTH = 64,
    parameter int WORD_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    advance,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    output logic [WORD_WIDTH-1:0]   first_word,
    output logic [WORD_WIDTH-1:0]   next_word,
    output logic                    last_word,
    output logic                    next_last
);

    localparam int WORDS_PER_SMP = (SAMPLE_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int PAD_WIDTH     = WORDS_PER_SMP * WORD_WIDTH;
    localparam int IDX_BITS      = (WORDS_PER_SMP > 1) ? $clog2(WORDS_PER_SMP) : 1;

    logic [PAD_WIDTH-1:0] padded_in;
    logic [PAD_WIDTH-1:0] sample_reg;
    logic [IDX_BITS-1:0]  word_idx;

    assign padded_in = PAD_WIDTH'(sample_in);

    // sample_reg keeps only the words not yet sent, shifted down so the next one sits at the bottom
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_reg <= '0;
            word_idx   <= '0;
        end else if (load) begin
            sample_reg <= padded_in >> WORD_WIDTH;
            word_idx   <= '0;
        end else if (advance && !last_word) begin
            sample_reg <= sample_reg >> WORD_WIDTH;
            word_idx   <= word_idx + 1'b1;
        end
    end

    assign first_word = padded_in[WORD_WIDTH-1:0];
    assign next_word  = sample_reg[WORD_WIDTH-1:0];
    assign last_word  = (int'(word_idx) == WORDS_PER_SMP - 1);
    assign next_last  = (int'(word_idx) == WORDS_PER_SMP - 2);

endmodule

// File: rtl/ila_readout_engine.sv
// Streams a completed capture buffer out oldest sample first, preceded by a header word carrying the trigger offset.
module ila_readout_engine
    import ila_pkg::*;
#(
    parameter int  DEPTH        = 1024,
    parameter int  SAMPLE_WIDTH = 64,
    parameter int  WORD_WIDTH   = ILA_READOUT_WORD_WIDTH,
    localparam int ADDR_BITS    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_BITS-1:0]    base_ptr,
    input  logic [ADDR_BITS-1:0]    trig_offset,
    output logic                    mem_rd_en,
    output logic [ADDR_BITS-1:0]    mem_rd_addr,
    input  logic [SAMPLE_WIDTH-1:0] mem_rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_WIDTH-1:0]   out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int WORDS_PER_SMP = (SAMPLE_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(DEPTH - 1);

    ila_readout_state_t    state;
    logic [ADDR_BITS-1:0]  base_q;
    logic [ADDR_BITS-1:0]  sample_idx;
    logic                  load;
    logic                  advance;
    logic [WORD_WIDTH-1:0] first_word;
    logic [WORD_WIDTH-1:0] next_word;
    logic                  last_word;
    logic                  next_last;

    assign load    = (state == WAIT);
    assign advance = (state == SEND) && out_ready && !abort;

    ila_word_serializer #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .WORD_WIDTH   (WORD_WIDTH)
    ) u_serializer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .advance    (advance),
        .sample_in  (mem_rd_data),
        .first_word (first_word),
        .next_word  (next_word),
        .last_word  (last_word),
        .next_last  (next_last)
    );

    // abort is checked ahead of the case so it beats any handshake in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            base_q      <= '0;
            sample_idx  <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            done      <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            base_q     <= base_ptr;
                            sample_idx <= '0;
                            out_data   <= WORD_WIDTH'(trig_offset);
                            out_valid  <= 1'b1;
                            out_last   <= 1'b0;
                            busy       <= 1'b1;
                            state      <= HEADER;
                        end
                    end
                    HEADER: begin
                        if (out_ready) begin
                            out_valid   <= 1'b0;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= base_q + sample_idx;
                            state       <= FETCH;
                        end
                    end
                    FETCH: state <= WAIT;
                    WAIT: begin
                        out_data  <= first_word;
                        out_valid <= 1'b1;
                        out_last  <= (WORDS_PER_SMP == 1) && (sample_idx == LAST_IDX);
                        state     <= SEND;
                    end
                    SEND: begin
                        if (out_ready) begin
                            if (!last_word) begin
                                out_data <= next_word;
                                out_last <= next_last && (sample_idx == LAST_IDX);
                            end else if (sample_idx == LAST_IDX) begin
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                out_valid   <= 1'b0;
                                sample_idx  <= sample_idx + 1'b1;
                                mem_rd_en   <= 1'b1;
                                mem_rd_addr <= base_q + sample_idx + 1'b1;
                                state       <= FETCH;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ila_readout_engine.sv
// Scoreboard bench: two engines (40-bit and 32-bit samples, DEPTH=8) fed by simple registered memory models.
module tb_ila_readout_engine;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int WW    = 32;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] base_ptr    = '0;
    logic [AW-1:0] trig_offset = '0;

    logic          start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b1;
    logic          a_rd_en, a_valid, a_last, a_busy, a_done;
    logic [AW-1:0] a_rd_addr;
    logic [39:0]   a_rd_data = '0;
    logic [WW-1:0] a_data;

    logic          start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b1;
    logic          b_rd_en, b_valid, b_last, b_busy, b_done;
    logic [AW-1:0] b_rd_addr;
    logic [31:0]   b_rd_data = '0;
    logic [WW-1:0] b_data;

    int total = 0;
    int bad   = 0;

    logic [WW:0]   qa[$];
    logic [WW:0]   qb[$];
    logic [AW-1:0] addr_qa[$];
    logic [AW-1:0] addr_qb[$];
    logic [WW:0]   exp_a, exp_b;
    int            acc_a = 0, done_a = 0, rd_a = 0, done_b = 0, rd_b = 0;
    bit            toggle_a = 1'b0;

    always #5 clk = ~clk;

    ila_readout_engine #(.DEPTH(DEPTH), .SAMPLE_WIDTH(40), .WORD_WIDTH(WW)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .base_ptr(base_ptr), .trig_offset(trig_offset),
        .mem_rd_en(a_rd_en), .mem_rd_addr(a_rd_addr), .mem_rd_data(a_rd_data),
        .out_valid(a_valid), .out_ready(ready_a), .out_data(a_data), .out_last(a_last),
        .busy(a_busy), .done(a_done)
    );

    ila_readout_engine #(.DEPTH(DEPTH), .SAMPLE_WIDTH(32), .WORD_WIDTH(WW)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .base_ptr(base_ptr), .trig_offset(trig_offset),
        .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr), .mem_rd_data(b_rd_data),
        .out_valid(b_valid), .out_ready(ready_b), .out_data(b_data), .out_last(b_last),
        .busy(b_busy), .done(b_done)
    );

    // Capture buffer models: mem[i] = A0_0000_0000|i and B000_0000|i, one-cycle read latency
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= 40'hA0_0000_0000 | 40'(a_rd_addr);
        if (b_rd_en) b_rd_data <= 32'hB000_0000 | 32'(b_rd_addr);
    end

    always @(negedge clk) begin
        if (toggle_a) ready_a = ~ready_a;
        else          ready_a = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Queue the expected stream and fetch addresses, then pulse start
    task automatic applyStimulus(input bit to_b, input logic [AW-1:0] base, input logic [AW-1:0] trig);
        logic [AW-1:0] addr;
        if (!to_b) qa.push_back({1'b0, WW'(trig)});
        else       qb.push_back({1'b0, WW'(trig)});
        for (int k = 0; k < DEPTH; k++) begin
            addr = base + AW'(k);
            if (!to_b) begin
                addr_qa.push_back(addr);
                qa.push_back({1'b0, WW'(addr)});
                qa.push_back({k == DEPTH - 1, 32'h0000_00A0});
            end else begin
                addr_qb.push_back(addr);
                qb.push_back({k == DEPTH - 1, 32'hB000_0000 | WW'(addr)});
            end
        end
        @(negedge clk);
        base_ptr    = base;
        trig_offset = trig;
        if (!to_b) start_a = 1'b1;
        else       start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic waitIdle(input bit to_b, input string name);
        int n = 0;
        while ((to_b ? b_busy : a_busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) checkOutput({name, "_timeout"}, 64'(n), 64'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic checkRun(input bit to_b, input string name);
        checkOutput({name, "_words_left"}, 64'(to_b ? qb.size() : qa.size()), 64'(0));
        checkOutput({name, "_done_pulses"}, 64'(to_b ? done_b : done_a), 64'(1));
        checkOutput({name, "_rd_strobes"}, 64'(to_b ? rd_b : rd_a), 64'(DEPTH));
        done_a = 0; rd_a = 0; acc_a = 0;
        done_b = 0; rd_b = 0;
    endtask

    // Monitors: pop on every accepted word, check held words during stalls and every fetch address
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (a_valid && ready_a && !abort_a) begin
                if (qa.size() == 0) checkOutput("a_extra_word", 64'(qa.size()), 64'(1));
                else begin
                    exp_a = qa.pop_front();
                    checkOutput("a_word", 64'({a_last, a_data}), 64'(exp_a));
                    acc_a++;
                end
            end else if (a_valid && !ready_a && qa.size() != 0) begin
                checkOutput("a_stall_hold", 64'({a_last, a_data}), 64'(qa[0]));
            end
            if (a_rd_en) begin
                if (addr_qa.size() == 0) checkOutput("a_extra_fetch", 64'(addr_qa.size()), 64'(1));
                else checkOutput("a_fetch_addr", 64'(a_rd_addr), 64'(addr_qa.pop_front()));
                rd_a++;
            end
            if (a_done) done_a++;
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (b_valid && ready_b && !abort_b) begin
                if (qb.size() == 0) checkOutput("b_extra_word", 64'(qb.size()), 64'(1));
                else begin
                    exp_b = qb.pop_front();
                    checkOutput("b_word", 64'({b_last, b_data}), 64'(exp_b));
                end
            end
            if (b_rd_en) begin
                if (addr_qb.size() == 0) checkOutput("b_extra_fetch", 64'(addr_qb.size()), 64'(1));
                else checkOutput("b_fetch_addr", 64'(b_rd_addr), 64'(addr_qb.pop_front()));
                rd_b++;
            end
            if (b_done) done_b++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", 64'(a_valid), 64'(0));
        checkOutput("reset_busy", 64'(a_busy), 64'(0));
        checkOutput("reset_done", 64'(a_done), 64'(0));
        checkOutput("reset_rd_en", 64'(a_rd_en), 64'(0));
        checkOutput("reset_data", 64'({a_last, a_data}), 64'(0));
        checkOutput("reset_b_valid", 64'(b_valid), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] T1 full readout, base 5, ready high");
        applyStimulus(1'b0, 3'd5, 3'd3);
        waitIdle(1'b0, "t1");
        checkRun(1'b0, "t1");

        $display("[TB] T2 same readout with ready toggling");
        toggle_a = 1'b1;
        applyStimulus(1'b0, 3'd5, 3'd3);
        waitIdle(1'b0, "t2");
        checkRun(1'b0, "t2");
        toggle_a = 1'b0;
        @(negedge clk);

        $display("[TB] start together with abort in IDLE");
        start_a = 1'b1;
        abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        abort_a = 1'b0;
        checkOutput("idle_abort_busy", 64'(a_busy), 64'(0));
        checkOutput("idle_abort_valid", 64'(a_valid), 64'(0));

        $display("[TB] T3 abort on sample 2 top word with ready high");
        applyStimulus(1'b0, 3'd5, 3'd3);
        n = 0;
        while (n < 500 && !(acc_a == 6 && a_valid)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) checkOutput("t3_reach_timeout", 64'(n), 64'(0));
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        checkOutput("t3_valid_after_abort", 64'(a_valid), 64'(0));
        checkOutput("t3_busy_after_abort", 64'(a_busy), 64'(0));
        checkOutput("t3_rd_strobes", 64'(rd_a), 64'(3));
        qa.delete();
        addr_qa.delete();
        repeat (4) @(negedge clk);
        checkOutput("t3_no_done", 64'(done_a), 64'(0));
        done_a = 0; rd_a = 0; acc_a = 0;
        applyStimulus(1'b0, 3'd2, 3'd6);
        waitIdle(1'b0, "t3_restart");
        checkRun(1'b0, "t3_restart");

        $display("[TB] T4 second start while busy");
        applyStimulus(1'b0, 3'd5, 3'd3);
        repeat (10) @(negedge clk);
        base_ptr    = 3'd1;
        trig_offset = 3'd7;
        start_a     = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        checkOutput("t4_busy_held", 64'(a_busy), 64'(1));
        waitIdle(1'b0, "t4");
        checkRun(1'b0, "t4");

        $display("[TB] T5 reset during FETCH");
        applyStimulus(1'b0, 3'd5, 3'd3);
        n = 0;
        while (n < 500 && !a_rd_en) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) checkOutput("t5_fetch_timeout", 64'(n), 64'(0));
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_valid", 64'(a_valid), 64'(0));
        checkOutput("t5_rst_rd_en", 64'(a_rd_en), 64'(0));
        checkOutput("t5_rst_rd_addr", 64'(a_rd_addr), 64'(0));
        checkOutput("t5_rst_busy", 64'(a_busy), 64'(0));
        checkOutput("t5_rst_data", 64'({a_last, a_data}), 64'(0));
        qa.delete();
        addr_qa.delete();
        done_a = 0; rd_a = 0; acc_a = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 3'd1);
        waitIdle(1'b0, "t5");
        checkRun(1'b0, "t5");

        $display("[TB] T6 one word per sample, base 0");
        applyStimulus(1'b1, 3'd0, 3'd4);
        waitIdle(1'b1, "t6");
        checkRun(1'b1, "t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
